dist_bcd_convert: RTL and testbench

DIST_BCD_CONVERT -- requirements
Module: dist_bcd_convert

---
 rtl/dist_pkg.sv | 18 +
 rtl/dist_bcd_add3.sv | 9 +
 rtl/dist_bcd_convert.sv | 136 +++++++++++++
 tb/tb_dist_bcd_convert.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/dist_pkg.sv
// Shared defaults, FSM state encoding and blank digit code for the distance-to-BCD converter.
// DIST_BCD_AVG4_EN adds the AVG state used by the optional 4-sample moving average.
package dist_pkg;

    localparam int DIST_W_DEF = 10;
    localparam int MAX_MM_DEF = 999;
    localparam logic [3:0] BCD_BLANK = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE,
`ifdef DIST_BCD_AVG4_EN
        ST_AVG,
`endif
        ST_SHIFT,
        ST_DONE
    } state_t;

endpackage

// File: rtl/dist_bcd_add3.sv
// Double-dabble digit correction: a digit of 5 or more gets 3 added before the next shift.
module dist_bcd_add3 (
    input  logic [3:0] digit,
    output logic [3:0] fixed
);

    assign fixed = (digit >= 4'd5) ? digit + 4'd3 : digit;

endmodule

// File: rtl/dist_bcd_convert.sv
// Binary mm distance to three BCD digits via sequential double-dabble, one bit per clock.
// Optional macro DIST_BCD_AVG4_EN inserts a 4-sample moving average ahead of the conversion.
module dist_bcd_convert
    import dist_pkg::*;
#(
    parameter int DIST_W = DIST_W_DEF,
    parameter int MAX_MM = MAX_MM_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              dist_valid,
    input  logic [DIST_W-1:0] dist_mm,
    input  logic              no_echo,
    output logic              busy,
    output logic              bcd_valid,
    output logic [3:0]        bcd_hund,
    output logic [3:0]        bcd_tens,
    output logic [3:0]        bcd_ones,
    output logic              over_range
);

    localparam int CNT_W = $clog2(DIST_W + 1);

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [DIST_W-1:0] bin;
    logic [11:0]       bcd;
    logic              over;

    logic [3:0]        fix_h, fix_t, fix_o;
    logic [11:0]       bcd_next;
    logic [DIST_W-1:0] bin_next;
    logic              shift_unused;

    dist_bcd_add3 u_add3_hund (.digit(bcd[11:8]), .fixed(fix_h));
    dist_bcd_add3 u_add3_tens (.digit(bcd[7:4]),  .fixed(fix_t));
    dist_bcd_add3 u_add3_ones (.digit(bcd[3:0]),  .fixed(fix_o));

    // Hundreds digit never exceeds 9 for in-range values, so its shifted-out MSB is discarded.
    assign {shift_unused, bcd_next, bin_next} = {fix_h, fix_t, fix_o, bin, 1'b0};

`ifdef DIST_BCD_AVG4_EN
    logic [DIST_W-1:0] avg_buf [4];
    logic              primed;
    logic [11:0]       avg_sum;
    logic [9:0]        avg_q;
    logic [1:0]        avg_rem_unused;

    assign avg_sum = 12'(avg_buf[0]) + 12'(avg_buf[1]) + 12'(avg_buf[2]) + 12'(avg_buf[3]);
    assign {avg_q, avg_rem_unused} = avg_sum;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            bin        <= '0;
            bcd        <= '0;
            over       <= 1'b0;
            busy       <= 1'b0;
            bcd_valid  <= 1'b0;
            bcd_hund   <= 4'd0;
            bcd_tens   <= 4'd0;
            bcd_ones   <= 4'd0;
            over_range <= 1'b0;
`ifdef DIST_BCD_AVG4_EN
            primed     <= 1'b0;
            for (int i = 0; i < 4; i++) avg_buf[i] <= '0;
`endif
        end else begin
            bcd_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (dist_valid) begin
                        busy <= 1'b1;
                        bin  <= dist_mm;
                        bcd  <= '0;
                        cnt  <= CNT_W'(DIST_W - 1);
                        over <= (32'(dist_mm) > MAX_MM);
                        if (no_echo) begin
                            state      <= ST_DONE;
                            bcd_valid  <= 1'b1;
                            over_range <= 1'b1;
                            bcd_hund   <= BCD_BLANK;
                            bcd_tens   <= BCD_BLANK;
                            bcd_ones   <= BCD_BLANK;
                        end else begin
`ifdef DIST_BCD_AVG4_EN
                            // First good sample after reset fills the whole window.
                            primed <= 1'b1;
                            if (!primed) begin
                                for (int i = 0; i < 4; i++) avg_buf[i] <= dist_mm;
                            end else begin
                                avg_buf[3] <= avg_buf[2];
                                avg_buf[2] <= avg_buf[1];
                                avg_buf[1] <= avg_buf[0];
                                avg_buf[0] <= dist_mm;
                            end
                            state <= ST_AVG;
`else
                            state <= ST_SHIFT;
`endif
                        end
                    end
                end
`ifdef DIST_BCD_AVG4_EN
                ST_AVG: begin
                    bin   <= DIST_W'(avg_q);
                    over  <= (32'(avg_q) > MAX_MM);
                    state <= ST_SHIFT;
                end
`endif
                ST_SHIFT: begin
                    bcd <= bcd_next;
                    bin <= bin_next;
                    if (cnt == '0) begin
                        state      <= ST_DONE;
                        bcd_valid  <= 1'b1;
                        over_range <= over;
                        bcd_hund   <= over ? BCD_BLANK : bcd_next[11:8];
                        bcd_tens   <= over ? BCD_BLANK : bcd_next[7:4];
                        bcd_ones   <= over ? BCD_BLANK : bcd_next[3:0];
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_DONE: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dist_bcd_convert.sv
// Directed bench for dist_bcd_convert: vector table plus drop, abort and averaging sequences.
// Honors DIST_BCD_AVG4_EN so the same file covers both builds.
module tb_dist_bcd_convert;

`ifdef DIST_BCD_AVG4_EN
    localparam int LAT = 12;
`else
    localparam int LAT = 11;
`endif
    localparam logic [12:0] BLANK = 13'h1FFF;

    logic       clk = 1'b0;
    logic       rst;
    logic       dist_valid;
    logic [9:0] dist_mm;
    logic       no_echo;
    logic       busy;
    logic       bcd_valid;
    logic [3:0] bcd_hund, bcd_tens, bcd_ones;
    logic       over_range;

    int total = 0;
    int bad = 0;

    typedef struct {
        logic [9:0]  d;
        logic        ne;
        logic [12:0] exp;
        int          lat;
    } vec_t;

    dist_bcd_convert dut (
        .clk       (clk),
        .rst       (rst),
        .dist_valid(dist_valid),
        .dist_mm   (dist_mm),
        .no_echo   (no_echo),
        .busy      (busy),
        .bcd_valid (bcd_valid),
        .bcd_hund  (bcd_hund),
        .bcd_tens  (bcd_tens),
        .bcd_ones  (bcd_ones),
        .over_range(over_range)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [12:0] outs();
        return {over_range, bcd_hund, bcd_tens, bcd_ones};
    endfunction

    // One strobe, then wait (bounded) for bcd_valid; lat=0 means it never came.
    task automatic convert(input logic [9:0] d, input logic ne,
                           output int lat, output int busy_cnt, output logic [12:0] res);
        @(negedge clk);
        dist_valid = 1'b1;
        dist_mm    = d;
        no_echo    = ne;
        lat        = 0;
        busy_cnt   = 0;
        res        = 'x;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            dist_valid = 1'b0;
            no_echo    = 1'b0;
            if (busy) busy_cnt++;
            if (bcd_valid) begin
                lat = k;
                res = outs();
                break;
            end
        end
    endtask

    task automatic run_vec(input string tag, input vec_t v);
        int lat, bc;
        logic [12:0] res;
        convert(v.d, v.ne, lat, bc, res);
        check({tag, " latency"}, lat, v.lat);
        check({tag, " busy cycles"}, bc, v.lat);
        check({tag, " result"}, {19'd0, res}, {19'd0, v.exp});
        @(negedge clk);
        check({tag, " valid one cycle"}, {31'd0, bcd_valid}, 0);
        check({tag, " busy released"}, {31'd0, busy}, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    vec_t vecs[10];
    vec_t avg_vecs[5];

    initial begin
        int pulses, first_lat;
        logic [12:0] first_res;

        vecs[0] = '{10'd0,    1'b0, 13'h0000, LAT};
        vecs[1] = '{10'd345,  1'b0, 13'h0345, LAT};
        vecs[2] = '{10'd1000, 1'b0, BLANK,    LAT};
        vecs[3] = '{10'd999,  1'b0, 13'h0999, LAT};
        vecs[4] = '{10'd123,  1'b1, BLANK,    1};
        vecs[5] = '{10'd7,    1'b0, 13'h0007, LAT};
        vecs[6] = '{10'd1023, 1'b0, BLANK,    LAT};
        vecs[7] = '{10'd509,  1'b0, 13'h0509, LAT};
        vecs[8] = '{10'd80,   1'b0, 13'h0080, LAT};
        vecs[9] = '{10'd100,  1'b0, 13'h0100, LAT};

        avg_vecs[0] = '{10'd100, 1'b0, 13'h0100, LAT};
        avg_vecs[1] = '{10'd200, 1'b0, 13'h0125, LAT};
        avg_vecs[2] = '{10'd123, 1'b1, BLANK,    1};
        avg_vecs[3] = '{10'd300, 1'b0, 13'h0175, LAT};
        avg_vecs[4] = '{10'd400, 1'b0, 13'h0250, LAT};

        rst        = 1'b1;
        dist_valid = 1'b0;
        dist_mm    = '0;
        no_echo    = 1'b0;
        repeat (3) @(negedge clk);
        check("reset outputs", {19'd0, outs()}, 0);
        check("reset busy", {31'd0, busy}, 0);
        check("reset valid", {31'd0, bcd_valid}, 0);
        rst = 1'b0;

`ifndef DIST_BCD_AVG4_EN
        for (int i = 0; i < 10; i++) begin
            run_vec($sformatf("vec%0d", i), vecs[i]);
        end
        repeat (6) @(negedge clk);
        check("hold after idle", {19'd0, outs()}, {19'd0, vecs[9].exp});
`endif

        // A second strobe mid-conversion must be ignored entirely.
        do_reset();
        @(negedge clk);
        dist_valid = 1'b1;
        dist_mm    = 10'd345;
        pulses     = 0;
        first_lat  = 0;
        first_res  = 'x;
        for (int k = 1; k <= 35; k++) begin
            @(negedge clk);
            dist_valid = (k == 3);
            dist_mm    = (k == 3) ? 10'd50 : 10'd345;
            if (bcd_valid) begin
                pulses++;
                if (pulses == 1) begin
                    first_lat = k;
                    first_res = outs();
                end
            end
        end
        dist_valid = 1'b0;
        check("drop pulses", pulses, 1);
        check("drop latency", first_lat, LAT);
        check("drop result", {19'd0, first_res}, 32'h0345);
        check("drop hold", {19'd0, outs()}, 32'h0345);

        // Reset in the middle of a conversion aborts it without a pulse.
        @(negedge clk);
        dist_valid = 1'b1;
        dist_mm    = 10'd345;
        pulses     = 0;
        for (int k = 1; k <= 25; k++) begin
            @(negedge clk);
            dist_valid = 1'b0;
            if (k == 5) rst = 1'b1;
            if (k == 7) rst = 1'b0;
            if (bcd_valid) pulses++;
        end
        check("abort pulses", pulses, 0);
        check("abort outputs", {19'd0, outs()}, 0);
        check("abort busy", {31'd0, busy}, 0);
        run_vec("after abort", '{10'd77, 1'b0, 13'h0077, LAT});

`ifdef DIST_BCD_AVG4_EN
        do_reset();
        for (int i = 0; i < 5; i++) begin
            run_vec($sformatf("avg%0d", i), avg_vecs[i]);
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
